// File: rtl/osd_wr_scheduler_pkg.sv
// osd_wr_scheduler_pkg: FSM encodings, OSDWrVector slice positions
// and default clear-sweep geometry for the OSD RAM write scheduler.
package osd_wr_scheduler_pkg;

  localparam int DEF_NUM_PAGES = 48;
  localparam int DEF_PAGE_SIZE = 16;

  localparam int WV_W     = 25;
  localparam int CTRL_HI  = 24;
  localparam int CTRL_LO  = 23;
  localparam int ADDR_HI  = 22;
  localparam int ADDR_LO  = 13;
  localparam int DATA_HI  = 12;
  localparam int DATA_LO  = 0;
  localparam int COLOR_HI = 12;
  localparam int COLOR_LO = 7;
  localparam int CHAR_HI  = 6;
  localparam int CHAR_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/osd_wr_fifo.sv
// osd_wr_fifo: synchronous FIFO holding queued CPU write vectors,
// with registered full/empty flags and occupancy.
module osd_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 25
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
  end

  // Entry storage; contents are only read while valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

  // Pointers, count and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == LW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign data_o  = mem_q[rp_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/osd_wr_scheduler.sv
// osd_wr_scheduler: arbitrates CPU FIFO writes and a clear-screen sweep
// into OSDWrVector; OSD_WR_VBLANK_GATE_EN enables window-active hold.
module osd_wr_scheduler
  import osd_wr_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_PAGES  = DEF_NUM_PAGES,
  parameter int PAGE_SIZE  = DEF_PAGE_SIZE
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        OSD_VSync,
  input  logic                        cpu_wr_valid,
  output logic                        cpu_wr_ready,
  input  logic [1:0]                  cpu_wr_ctrl,
  input  logic [9:0]                  cpu_wr_addr,
  input  logic [12:0]                 cpu_wr_data,
  input  logic                        clr_start,
  input  logic [6:0]                  clr_char,
  input  logic [5:0]                  clr_color,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [WV_W-1:0]             OSDWrVector
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [5:0] LAST_PAGE = 6'(NUM_PAGES - 1);
  localparam logic [3:0] LAST_ROW  = 4'(PAGE_SIZE - 1);

  wr_state_e        state_q, state_d;
  wr_state_e        saved_q, saved_d;
  logic [5:0]       page_q;
  logic [3:0]       row_q;
  logic [6:0]       fchar_q;
  logic [5:0]       fcolor_q;
  logic             busy_q, last_q, done_q;
  logic [WV_W-1:0]  wr_q, wr_d;
  logic [WV_W-1:0]  fifo_wdata, fifo_rdata;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_lvl;
  logic             gate, clr_acc, clr_issue, sweep_last;

`ifdef OSD_WR_VBLANK_GATE_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for the VCLK-domain window flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= OSD_VSync;
      sync2_q <= sync1_q;
    end
  end

  assign gate = sync2_q;
`else
  logic unused_vsync;
  assign unused_vsync = OSD_VSync;
  assign gate = 1'b0;
`endif

  assign cpu_wr_ready = ~fifo_full;
  assign fifo_push    = cpu_wr_valid & ~fifo_full & (|cpu_wr_ctrl);
  assign clr_acc      = clr_start & ~busy_q;
  assign sweep_last   = (page_q == LAST_PAGE) && (row_q == LAST_ROW);

  // Pack the CPU request into vector layout for queueing.
  always_comb begin
    fifo_wdata = '0;
    fifo_wdata[CTRL_HI:CTRL_LO] = cpu_wr_ctrl;
    fifo_wdata[ADDR_HI:ADDR_LO] = cpu_wr_addr;
    fifo_wdata[DATA_HI:DATA_LO] = cpu_wr_data;
  end

  osd_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WV_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  // Next-state, issue selection and output vector.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    fifo_pop  = 1'b0;
    clr_issue = 1'b0;
    wr_d      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_acc)          state_d = ST_CLEAR;
        else if (!fifo_empty) state_d = ST_CPU;
      end
      ST_CPU: begin
        if (clr_acc) begin
          state_d = ST_CLEAR;
        end else if (gate) begin
          state_d = ST_HOLD;
          saved_d = ST_CPU;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wr_d     = fifo_rdata;
          if (fifo_lvl == LW'(1) && !fifo_push)
            state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (gate) begin
          state_d = ST_HOLD;
          saved_d = ST_CLEAR;
        end else begin
          clr_issue = 1'b1;
          wr_d[CTRL_HI:CTRL_LO]   = 2'b11;
          wr_d[ADDR_HI:ADDR_LO]   = {page_q, row_q};
          wr_d[COLOR_HI:COLOR_LO] = fcolor_q;
          wr_d[CHAR_HI:CHAR_LO]   = fchar_q;
          if (sweep_last)
            state_d = fifo_empty ? ST_IDLE : ST_CPU;
        end
      end
      ST_HOLD: begin
        if (clr_acc) saved_d = ST_CLEAR;
        if (!gate)   state_d = clr_acc ? ST_CLEAR : saved_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and output vector registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      wr_q    <= wr_d;
    end
  end

  // Clear sweep counters, fill values and busy/done tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      page_q   <= '0;
      row_q    <= '0;
      fchar_q  <= '0;
      fcolor_q <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (clr_acc) begin
        busy_q   <= 1'b1;
        fchar_q  <= clr_char;
        fcolor_q <= clr_color;
        page_q   <= '0;
        row_q    <= '0;
      end else if (clr_issue) begin
        if (row_q == LAST_ROW) begin
          row_q  <= '0;
          page_q <= page_q + 1'b1;
        end else begin
          row_q  <= row_q + 1'b1;
        end
      end
      last_q <= clr_issue & sweep_last;
      done_q <= last_q;
      if (last_q) busy_q <= 1'b0;
    end
  end

  assign clr_busy    = busy_q;
  assign clr_done    = done_q;
  assign fifo_level  = fifo_lvl;
  assign OSDWrVector = wr_q;

endmodule
